// File: rtl/rtc_pkg.sv
// Shared types, limits and helpers for the real-time-clock core.
// Contents: BCD digit/byte typedefs, per-field maximum values, the set
// handshake state encoding, a BCD range check and the 24 h -> 12 h
// display conversion.
package rtc_pkg;

  typedef logic [3:0] bcd_digit_t;
  typedef logic [7:0] bcd_byte_t;

  localparam bcd_byte_t MAX_SEC  = 8'h59;
  localparam bcd_byte_t MAX_MIN  = 8'h59;
  localparam bcd_byte_t MAX_HOUR = 8'h23;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOADED = 1'b1
  } set_state_e;

  // True when both digits are decimal and the value does not exceed max_v.
  // With two decimal digits the packed byte orders like the decimal value,
  // so a plain unsigned compare is enough for the range test.
  function automatic logic bcd_valid(input bcd_byte_t v, input bcd_byte_t max_v);
    return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9) && (v <= max_v);
  endfunction

  // 00 -> 12, 01..12 unchanged, 13..23 -> 01..11, done directly in BCD.
  // 13..19 and 22..23 drop 0x12 without a digit borrow; 20..21 need 0x18
  // because the ones digit borrows across the tens boundary.
  function automatic bcd_byte_t hour_24_to_12(input bcd_byte_t h);
    bcd_byte_t r;
    r = h;
    if (h == 8'h00) begin
      r = 8'h12;
    end else if (h >= 8'h13) begin
      if (h == 8'h20 || h == 8'h21) begin
        r = h - 8'h18;
      end else begin
        r = h - 8'h12;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/rtc_bcd_mod_counter.sv
// Two-digit BCD modulo counter used for seconds, minutes and hours.
// Ports:
//   clk, rst      clock and synchronous active-high reset (clears to 00)
//   inc           advance by one (wraps MAX_VAL -> 00)
//   load          parallel load of load_val; has priority over inc
//   load_val      BCD value to load
//   val           registered count
//   nxt           value the count takes on the next edge
//   carry         high when inc wraps the count this cycle
module bcd_mod_counter
  import rtc_pkg::*;
#(
  parameter logic [7:0] MAX_VAL = 8'h59
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       inc,
  input  logic       load,
  input  logic [7:0] load_val,
  output logic [7:0] val,
  output logic [7:0] nxt,
  output logic       carry
);

  bcd_byte_t val_q;
  bcd_byte_t val_d;

  always_comb begin
    val_d = val_q;
    carry = 1'b0;
    if (load) begin
      val_d = load_val;
    end else if (inc) begin
      if (val_q == MAX_VAL) begin
        val_d = 8'h00;
        carry = 1'b1;
      end else if (val_q[3:0] == 4'd9) begin
        val_d = {val_q[7:4] + 4'd1, 4'd0};
      end else begin
        val_d = {val_q[7:4], val_q[3:0] + 4'd1};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      val_q <= 8'h00;
    end else begin
      val_q <= val_d;
    end
  end

  assign val = val_q;
  assign nxt = val_d;

endmodule

// File: rtl/rtc_timekeeper.sv
// Real-time-clock core: divides the input clock to a 1 Hz tick and keeps
// BCD hh:mm:ss, with a validated time-load handshake, 12/24 h display and a
// latched alarm.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   run                           1 = time advances, 0 = prescaler and time hold
//   mode_12h                      display hour in 12 h format
//   set_valid/set_ready           time-load handshake
//   set_hour/set_min/set_sec      BCD time to load (24 h)
//   set_err                       one-cycle pulse on a rejected load
//   alarm_en/alarm_hour/alarm_min alarm compare controls (24 h BCD)
//   alarm_ack                     clears alarm_ring
//   alarm_ring                    latched alarm flag
//   tick_1hz                      one-cycle pulse coincident with each new second
//   hour_bcd/min_bcd/sec_bcd      displayed time
//   pm                            internal hour >= 12
module rtc_timekeeper
  import rtc_pkg::*;
#(
  parameter int CLK_HZ   = 32768,
  parameter int TICK_DIV = CLK_HZ,
  parameter int PRE_W    = $clog2(TICK_DIV)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic       mode_12h,
  input  logic       set_valid,
  output logic       set_ready,
  input  logic [7:0] set_hour,
  input  logic [7:0] set_min,
  input  logic [7:0] set_sec,
  output logic       set_err,
  input  logic       alarm_en,
  input  logic [7:0] alarm_hour,
  input  logic [7:0] alarm_min,
  input  logic       alarm_ack,
  output logic       alarm_ring,
  output logic       tick_1hz,
  output logic [7:0] hour_bcd,
  output logic [7:0] min_bcd,
  output logic [7:0] sec_bcd,
  output logic       pm
);

  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

  set_state_e       state_q, state_d;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic             tick_q, tick_d;
  logic             err_q, err_d;
  logic             ring_q, ring_d;

  logic      accept, set_ok, do_load, terminal, tick_now, fire, alarm_match;
  logic      sec_carry, min_carry, unused_day_wrap;
  bcd_byte_t sec_val, min_val, hour_val;
  bcd_byte_t sec_nxt, min_nxt, hour_nxt;

  assign set_ready = (state_q == ST_IDLE);
  assign accept    = set_valid && set_ready;
  assign set_ok    = bcd_valid(set_hour, MAX_HOUR) && bcd_valid(set_min, MAX_MIN) &&
                     bcd_valid(set_sec, MAX_SEC);
  assign do_load   = accept && set_ok;
  assign terminal  = run && (pre_q == PRE_LAST);
  // A valid load takes the edge; a coincident tick is dropped.
  assign tick_now  = terminal && !do_load;

  always_comb begin
    state_d = (accept) ? ST_LOADED : ST_IDLE;
    err_d   = accept && !set_ok;
    tick_d  = tick_now;
    pre_d   = pre_q;
    if (do_load) begin
      pre_d = '0;
    end else if (run) begin
      pre_d = terminal ? '0 : pre_q + 1'b1;
    end
  end

  bcd_mod_counter #(.MAX_VAL(MAX_SEC)) u_sec (
    .clk(clk), .rst(rst), .inc(tick_now), .load(do_load), .load_val(set_sec),
    .val(sec_val), .nxt(sec_nxt), .carry(sec_carry)
  );

  bcd_mod_counter #(.MAX_VAL(MAX_MIN)) u_min (
    .clk(clk), .rst(rst), .inc(sec_carry), .load(do_load), .load_val(set_min),
    .val(min_val), .nxt(min_nxt), .carry(min_carry)
  );

  bcd_mod_counter #(.MAX_VAL(MAX_HOUR)) u_hour (
    .clk(clk), .rst(rst), .inc(min_carry), .load(do_load), .load_val(set_hour),
    .val(hour_val), .nxt(hour_nxt), .carry(unused_day_wrap)
  );

  // The alarm compares against the time the counters are about to take, so
  // the ring latches on the same edge as the matching time appears.
  assign alarm_match = bcd_valid(alarm_hour, MAX_HOUR) && bcd_valid(alarm_min, MAX_MIN) &&
                       (hour_nxt == alarm_hour) && (min_nxt == alarm_min) &&
                       (sec_nxt == 8'h00);
  assign fire = alarm_en && (tick_now || do_load) && alarm_match;

  always_comb begin
    ring_d = ring_q;
    if (fire) begin
      ring_d = 1'b1;
    end else if (alarm_ack) begin
      ring_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      pre_q   <= '0;
      tick_q  <= 1'b0;
      err_q   <= 1'b0;
      ring_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pre_q   <= pre_d;
      tick_q  <= tick_d;
      err_q   <= err_d;
      ring_q  <= ring_d;
    end
  end

  assign tick_1hz   = tick_q;
  assign set_err    = err_q;
  assign alarm_ring = ring_q;
  assign sec_bcd    = sec_val;
  assign min_bcd    = min_val;
  assign hour_bcd   = mode_12h ? hour_24_to_12(hour_val) : hour_val;
  assign pm         = (hour_val >= 8'h12);

endmodule

// File: tb/tb_rtc_timekeeper.sv
module tb_rtc_timekeeper;

  localparam int DIV = 4;
  localparam int DAY = 86400;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       run = 1'b0;
  logic       mode_12h = 1'b0;
  logic       set_valid = 1'b0;
  logic       set_ready;
  logic [7:0] set_hour = 8'h00, set_min = 8'h00, set_sec = 8'h00;
  logic       set_err;
  logic       alarm_en = 1'b0;
  logic [7:0] alarm_hour = 8'h00, alarm_min = 8'h00;
  logic       alarm_ack = 1'b0;
  logic       alarm_ring, tick_1hz, pm;
  logic [7:0] hour_bcd, min_bcd, sec_bcd;

  rtc_timekeeper #(.CLK_HZ(32768), .TICK_DIV(DIV)) dut (
    .clk(clk), .rst(rst), .run(run), .mode_12h(mode_12h),
    .set_valid(set_valid), .set_ready(set_ready),
    .set_hour(set_hour), .set_min(set_min), .set_sec(set_sec), .set_err(set_err),
    .alarm_en(alarm_en), .alarm_hour(alarm_hour), .alarm_min(alarm_min),
    .alarm_ack(alarm_ack), .alarm_ring(alarm_ring), .tick_1hz(tick_1hz),
    .hour_bcd(hour_bcd), .min_bcd(min_bcd), .sec_bcd(sec_bcd), .pm(pm)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  // Reference model: time as seconds-of-day, prescaler as a plain count.
  int m_t = 0, m_pre = 0;
  bit m_tick = 0, m_err = 0, m_ready = 1, m_ring = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  function automatic int bcd2int(input logic [7:0] b);
    return int'(b[7:4]) * 10 + int'(b[3:0]);
  endfunction

  function automatic bit in_range(input logic [7:0] b, input int max);
    return (b[7:4] <= 4'd9) && (b[3:0] <= 4'd9) && (bcd2int(b) <= max);
  endfunction

  function automatic logic [7:0] to_bcd(input int n);
    logic [7:0] r;
    r[7:4] = 4'((n / 10) % 10);
    r[3:0] = 4'(n % 10);
    return r;
  endfunction

  function automatic logic [7:0] exp_hour(input int t, input bit m12);
    int h;
    h = t / 3600;
    if (!m12) return to_bcd(h);
    return to_bcd((h % 12 == 0) ? 12 : h % 12);
  endfunction

  task automatic model_update();
    bit accept, ok, load, term, fire;
    if (rst) begin
      m_t = 0; m_pre = 0; m_tick = 0; m_err = 0; m_ready = 1; m_ring = 0;
      return;
    end
    accept = set_valid && m_ready;
    ok = in_range(set_hour, 23) && in_range(set_min, 59) && in_range(set_sec, 59);
    load = accept && ok;
    term = run && (m_pre == DIV - 1);
    m_tick = 0;
    if (load) begin
      m_t = bcd2int(set_hour) * 3600 + bcd2int(set_min) * 60 + bcd2int(set_sec);
      m_pre = 0;
    end else begin
      if (run) m_pre = (m_pre + 1) % DIV;
      if (term) begin
        m_tick = 1;
        m_t = (m_t + 1) % DAY;
      end
    end
    fire = alarm_en && (load || m_tick) && in_range(alarm_hour, 23) &&
           in_range(alarm_min, 59) &&
           (m_t == bcd2int(alarm_hour) * 3600 + bcd2int(alarm_min) * 60);
    if (fire) m_ring = 1;
    else if (alarm_ack) m_ring = 0;
    m_err = accept && !ok;
    m_ready = !accept;
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    check("tick", tick_1hz, m_tick);
    check("set_err", set_err, m_err);
    check("set_ready", set_ready, m_ready);
    check("ring", alarm_ring, m_ring);
    check("sec", sec_bcd, to_bcd(m_t % 60));
    check("min", min_bcd, to_bcd((m_t / 60) % 60));
    check("hour", hour_bcd, exp_hour(m_t, mode_12h));
    check("pm", pm, (m_t / 3600) >= 12);
  endtask

  task automatic load_time(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
    set_hour = h; set_min = m; set_sec = s; set_valid = 1'b1;
    step();
    set_valid = 1'b0;
  endtask

  task automatic wait_tick(input string tag);
    int n;
    n = 0;
    while (!m_tick && n < 3 * DIV) begin
      step();
      n++;
    end
    check(tag, {31'd0, tick_1hz}, 32'd1);
  endtask

  initial begin
    int ticks;
    logic [23:0] hold;

    // Reset state, both display modes
    rst = 1'b1;
    step();
    check("rst_hour24", hour_bcd, 8'h00);
    mode_12h = 1'b1;
    step();
    check("rst_hour12", hour_bcd, 8'h12);
    rst = 1'b0; mode_12h = 1'b0; run = 1'b1;

    // 240 ticks from reset -> 00:04:00
    ticks = 0;
    for (int i = 0; i < 240 * DIV; i++) begin
      step();
      if (tick_1hz) ticks++;
    end
    check("tick_count", ticks, 240);
    check("t240", {hour_bcd, min_bcd, sec_bcd}, 24'h000400);

    // Day wrap with pm and 12 h readout
    mode_12h = 1'b1;
    load_time(8'h23, 8'h59, 8'h58);
    wait_tick("wrap_t1");
    check("wrap_h11", hour_bcd, 8'h11);
    step();
    wait_tick("wrap_t2");
    check("wrap_h12", hour_bcd, 8'h12);
    check("wrap_pm", pm, 1'b0);
    mode_12h = 1'b0;

    // Invalid loads
    load_time(8'h12, 8'h60, 8'h00);
    check("rej1_err", set_err, 1'b1);
    step();
    load_time(8'h1A, 8'h00, 8'h00);
    check("rej2_err", set_err, 1'b1);
    check("rej2_ready", set_ready, 1'b0);
    step();

    // Load in the prescaler terminal cycle drops the tick
    for (int i = 0; i < 2 * DIV && m_pre != DIV - 1; i++) step();
    load_time(8'h08, 8'h30, 8'h00);
    check("term_load", {hour_bcd, min_bcd, sec_bcd}, 24'h083000);
    check("term_notick", tick_1hz, 1'b0);
    for (int i = 0; i < DIV; i++) step();
    check("term_next", {hour_bcd, min_bcd, sec_bcd, 7'd0, tick_1hz}, 32'h08300101);

    // Alarm fires, then ack clears it; disabled alarm stays quiet
    alarm_en = 1'b1; alarm_hour = 8'h07; alarm_min = 8'h15;
    load_time(8'h07, 8'h14, 8'h59);
    wait_tick("alm_tick");
    check("alm_ring", alarm_ring, 1'b1);
    alarm_ack = 1'b1;
    step();
    alarm_ack = 1'b0;
    check("alm_ack", alarm_ring, 1'b0);
    alarm_en = 1'b0;
    load_time(8'h07, 8'h14, 8'h59);
    wait_tick("alm_off_tick");
    check("alm_off", alarm_ring, 1'b0);

    // Freeze, then reset mid-count with a latched ring
    alarm_en = 1'b1;
    load_time(8'h07, 8'h15, 8'h00);
    step();
    hold = {hour_bcd, min_bcd, sec_bcd};
    run = 1'b0;
    for (int i = 0; i < 20; i++) step();
    check("frozen", {hour_bcd, min_bcd, sec_bcd}, hold);
    run = 1'b1;
    step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst", {hour_bcd, min_bcd, sec_bcd, 7'd0, alarm_ring}, 32'h00000000);

    // Randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      run       = ($urandom_range(0, 9) != 0);
      mode_12h  = $urandom_range(0, 1) != 0;
      rst       = ($urandom_range(0, 499) == 0);
      alarm_ack = ($urandom_range(0, 15) == 0);
      alarm_en  = ($urandom_range(0, 3) != 0);
      set_valid = ($urandom_range(0, 11) == 0);
      if ($urandom_range(0, 1) != 0) begin
        set_hour = to_bcd($urandom_range(0, 23));
        set_min  = to_bcd($urandom_range(0, 59));
        set_sec  = to_bcd($urandom_range(50, 59));
      end else begin
        set_hour = 8'($urandom); set_min = 8'($urandom); set_sec = 8'($urandom);
      end
      if ($urandom_range(0, 63) == 0) begin
        if ($urandom_range(0, 3) == 0) begin
          alarm_hour = 8'($urandom); alarm_min = 8'($urandom);
        end else begin
          alarm_hour = to_bcd(((m_t + 30) % DAY) / 3600);
          alarm_min  = to_bcd((((m_t + 30) % DAY) / 60) % 60);
        end
      end
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/rtc_timekeeper.md
Name: rtc_timekeeper

Overview:
Parametrised real-time-clock core for the clock design. It divides the 32.768 kHz system clock to a 1 Hz tick and keeps BCD hours:minutes:seconds. Adds a validated time-set handshake, 12/24-hour display mode and a latched alarm, none of which the first-generation clock had. It feeds the display/segment driver in the top-level wrapper.

Parameters:
CLK_HZ, 32768, input clock frequency in Hz; the prescaler divides by this value.
TICK_DIV, CLK_HZ, actual divide ratio; benches override it (e.g. 4) for fast simulation; must be >= 2.
PRE_W, $clog2(TICK_DIV), prescaler counter width.

Ports:
clk  in  1  system clock (32.768 kHz nominal)
rst  in  1  synchronous reset, active-high
run  in  1  1 = timekeeping advances; 0 = time frozen, prescaler held
mode_12h  in  1  1 = hour_bcd shown in 12 h format; 0 = 24 h
set_valid  in  1  time-load request
set_ready  out  1  core can accept a load this cycle
set_hour  in  8  BCD hour to load, 24 h format (00-23)
set_min  in  8  BCD minute (00-59)
set_sec  in  8  BCD second (00-59)
set_err  out  1  one-cycle pulse: the offered load was rejected as invalid
alarm_en  in  1  alarm compare enable
alarm_hour  in  8  BCD alarm hour, 24 h
alarm_min  in  8  BCD alarm minute
alarm_ack  in  1  clears alarm_ring
alarm_ring  out  1  latched alarm flag
tick_1hz  out  1  one-cycle pulse on each second advance
hour_bcd  out  8  displayed hour (24 h, or 01-12 in 12 h mode)
min_bcd  out  8  minutes
sec_bcd  out  8  seconds
pm  out  1  1 when internal hour >= 12 (valid in both modes)

Behaviour:
- Reset (rst=1 at a clk edge): prescaler=0, time 00:00:00, tick_1hz=0, set_err=0, alarm_ring=0, set_ready=1. Displayed outputs after reset: hour_bcd=00 in 24 h mode, 12 in 12 h mode; pm=0. Reset overrides every other input.
- Prescaler counts 0..TICK_DIV-1 while run=1 and wraps to 0. In the cycle it equals TICK_DIV-1, the time registers and tick_1hz update on the next edge. tick_1hz is high for exactly one cycle, coincident with the new time. One tick every TICK_DIV cycles.
- Second advance is BCD: ones digit 9 -> 0 with carry into tens; sec 59 -> 00 carries into minutes; min 59 -> 00 carries into hours; hour 23 -> 00, full day wrap. No binary intermediates may appear on the outputs.
- run=0: prescaler and time hold; no tick is issued.
- Set handshake: a load is accepted when set_valid & set_ready at an edge.
  - set_ready=1 except in the single cycle after an accepted or rejected load, when it is 0.
  - Validity check: each BCD digit <= 9, hour <= 23, min/sec <= 59.
  - Valid load: time registers take the set values on that edge, prescaler clears to 0, and no tick is produced that cycle. A load beats a simultaneous tick; the tick is dropped.
  - Invalid load: time is unchanged, the prescaler keeps counting, and set_err pulses for 1 cycle.
- States: IDLE (set_ready=1) -> LOADED (1 cycle, set_ready=0) -> IDLE.
- 12 h display is combinational from the internal 24 h registers: hour 00 -> 12 (pm=0), 01-11 unchanged, 12 -> 12 (pm=1), 13-23 -> 01-11 (pm=1).
- Alarm fires on a tick whose resulting time equals alarm_hour:alarm_min:00 while alarm_en=1. A valid load that lands exactly on the alarm time also fires it.
  - Firing sets alarm_ring on the same edge the time updates.
  - alarm_ack clears alarm_ring on the next edge. If ack and a new firing occur together, the firing wins and the ring stays 1.
  - Deasserting alarm_en does not clear an already latched ring.
- Invalid alarm values (non-BCD or out of range) never match; no error is reported for them.

Decomposition:
- Shared package rtc_pkg: BCD digit/byte typedefs, MAX_SEC=8'h59, MAX_MIN=8'h59, MAX_HOUR=8'h23, the bcd_valid function and the 24->12 h conversion function.
- One natural sub-module: bcd_mod_counter (two BCD digits, parametrised max value, inc/load inputs, carry-out). Instantiate it three times, chained by carry.

Test Plan:
- Reset then run=1 with TICK_DIV=4 -> tick_1hz every 4 cycles; after 240 ticks the time is 00:04:00; sec_bcd shows 09 -> 10 (never 0A).
- Load 23:59:58 then run -> 23:59:59, then 00:00:00 on the 2nd tick, pm 1 -> 0; with mode_12h=1, hour_bcd reads 11 then 12.
- Offer set 12:60:00 -> set_err pulses 1 cycle, time unchanged, set_ready low for 1 cycle; offer 1A:00:00 -> rejected the same way.
- Assert set_valid in the prescaler terminal cycle with 08:30:00 -> time = 08:30:00 with no tick; the next tick comes 4 cycles later at 08:30:01.
- alarm_en=1, alarm 07:15 -> load 07:14:59; one tick later alarm_ring=1; pulse alarm_ack -> ring 0; with alarm_en=0 the same sequence leaves ring at 0.
- run=0 for 20 cycles mid-count -> outputs frozen, no tick; asserting rst mid-count -> 00:00:00 next edge, alarm_ring cleared.
